// File: rtl/if_fetch_ctrl.sv
// ============================================================================
// Module  : if_fetch_ctrl
// Brief   : Pre-IF fetch controller. Issues instruction fetches, buffers one
//           returned instruction for IF, and handles flush/branch redirects.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module if_fetch_ctrl #(
   parameter logic [31:0] RESET_PC = 32'hbfc00000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        ws_handle_ex,
   input  logic [31:0] ex_pc,
   input  logic        br_taken,
   input  logic [31:0] br_target,
   output logic        inst_req,
   output logic [31:0] inst_addr,
   input  logic        inst_addr_ok,
   input  logic        inst_data_ok,
   input  logic [31:0] inst_rdata,
   input  logic        fs_allowin,
   output logic        fs_valid,
   output logic [31:0] fs_pc,
   output logic [31:0] fs_inst,
   output logic        fs_adel
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_REQ  = 2'd1,
      S_WAIT = 2'd2,
      S_HOLD = 2'd3
   } state_t;

   state_t      r_state;
   logic [31:0] r_pc;
   logic [31:0] r_addr;
   logic        r_cancel;
   logic        r_req;
   logic        r_fs_valid;
   logic        r_adel;
   logic [31:0] r_inst;

   logic        w_redir;
   logic [31:0] w_target;

   assign w_redir  = ws_handle_ex | br_taken;
   assign w_target = ws_handle_ex ? ex_pc : br_target;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state    <= S_IDLE;
         r_pc       <= RESET_PC;
         r_addr     <= RESET_PC;
         r_cancel   <= 1'b0;
         r_req      <= 1'b0;
         r_fs_valid <= 1'b0;
         r_adel     <= 1'b0;
         r_inst     <= 32'd0;
      end else begin
         if (w_redir) begin
            r_pc <= w_target;
         end
         case (r_state)
            S_IDLE: begin
               if (w_redir) begin
                  r_state <= S_IDLE;
               end else if (r_pc[1:0] != 2'b00) begin
                  r_state    <= S_HOLD;
                  r_fs_valid <= 1'b1;
                  r_adel     <= 1'b1;
                  r_inst     <= 32'd0;
               end else begin
                  r_state <= S_REQ;
                  r_req   <= 1'b1;
                  r_addr  <= r_pc;
               end
            end
            S_REQ: begin
               // A request already on the bus must complete; its response is dropped later.
               if (w_redir) begin
                  r_cancel <= 1'b1;
               end
               if (inst_addr_ok) begin
                  r_req   <= 1'b0;
                  r_state <= S_WAIT;
               end
            end
            S_WAIT: begin
               if (inst_data_ok) begin
                  r_cancel <= 1'b0;
                  if (r_cancel || w_redir) begin
                     r_state <= S_IDLE;
                  end else begin
                     r_state    <= S_HOLD;
                     r_fs_valid <= 1'b1;
                     r_adel     <= 1'b0;
                     r_inst     <= inst_rdata;
                  end
               end else if (w_redir) begin
                  r_cancel <= 1'b1;
               end
            end
            S_HOLD: begin
               // Redirect wins over a same-cycle accept: the buffered instruction is discarded.
               if (w_redir) begin
                  r_state    <= S_IDLE;
                  r_fs_valid <= 1'b0;
                  r_adel     <= 1'b0;
               end else if (fs_allowin) begin
                  r_pc       <= r_pc + 32'd4;
                  r_state    <= S_IDLE;
                  r_fs_valid <= 1'b0;
                  r_adel     <= 1'b0;
               end
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign inst_req  = r_req;
   assign inst_addr = r_addr;
   assign fs_valid  = r_fs_valid;
   assign fs_pc     = r_pc;
   assign fs_inst   = r_inst;
   assign fs_adel   = r_adel;

endmodule

`default_nettype wire

// File: tb/tb_if_fetch_ctrl.sv
// ============================================================================
// Module  : tb_if_fetch_ctrl
// Brief   : Self-checking bench for if_fetch_ctrl with SRAM slave and IF sink.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_if_fetch_ctrl;

   localparam logic [31:0] C_KEY = 32'h1357_9bdf;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] inst;
      logic        adel;
   } dlv_t;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        ws_handle_ex = 1'b0;
   logic [31:0] ex_pc = 32'd0;
   logic        br_taken = 1'b0;
   logic [31:0] br_target = 32'd0;
   logic        inst_req;
   logic [31:0] inst_addr;
   logic        inst_addr_ok = 1'b0;
   logic        inst_data_ok = 1'b0;
   logic [31:0] inst_rdata = 32'd0;
   logic        fs_allowin = 1'b0;
   logic        fs_valid;
   logic [31:0] fs_pc;
   logic [31:0] fs_inst;
   logic        fs_adel;

   int          n_checks = 0;
   int          n_errors = 0;

   logic [31:0] req_q[$];
   dlv_t        dlv_q[$];

   bit          aok_en = 1'b1;
   bit          allow_en = 1'b1;
   bit          force_allow = 1'b0;
   bit          busy = 1'b0;
   int          lat = 1;
   int          cnt = 0;
   logic [31:0] paddr = 32'd0;

   if_fetch_ctrl #(.RESET_PC(32'hbfc00000)) u_dut (
      .clk          (clk),
      .reset        (reset),
      .ws_handle_ex (ws_handle_ex),
      .ex_pc        (ex_pc),
      .br_taken     (br_taken),
      .br_target    (br_target),
      .inst_req     (inst_req),
      .inst_addr    (inst_addr),
      .inst_addr_ok (inst_addr_ok),
      .inst_data_ok (inst_data_ok),
      .inst_rdata   (inst_rdata),
      .fs_allowin   (fs_allowin),
      .fs_valid     (fs_valid),
      .fs_pc        (fs_pc),
      .fs_inst      (fs_inst),
      .fs_adel      (fs_adel)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   // SRAM slave and IF sink: inputs for the next edge are decided on the falling edge.
   always @(negedge clk) begin
      if (reset) begin
         busy         = 1'b0;
         inst_addr_ok = 1'b0;
         inst_data_ok = 1'b0;
         fs_allowin   = 1'b0;
      end else begin
         inst_data_ok = 1'b0;
         if (busy) begin
            if (cnt <= 1) begin
               inst_data_ok = 1'b1;
               inst_rdata   = paddr ^ C_KEY;
               busy         = 1'b0;
            end else begin
               cnt--;
            end
         end
         inst_addr_ok = 1'b0;
         if (!busy && inst_req && aok_en && req_q.size() > 0) begin
            check("req_addr", inst_addr, req_q.pop_front());
            busy         = 1'b1;
            cnt          = lat;
            paddr        = inst_addr;
            inst_addr_ok = 1'b1;
         end
         fs_allowin = allow_en && (force_allow || dlv_q.size() > 0);
         if (fs_valid && fs_allowin && !(ws_handle_ex || br_taken)) begin
            if (dlv_q.size() == 0) begin
               check("dlv_unexpected", fs_pc, 32'hffff_ffff);
            end else begin
               dlv_t e;
               e = dlv_q.pop_front();
               check("dlv_pc", fs_pc, e.pc);
               check("dlv_inst", fs_inst, e.inst);
               check("dlv_adel", {31'd0, fs_adel}, {31'd0, e.adel});
            end
         end
      end
   end

   task automatic push_fetch(input logic [31:0] a);
      dlv_t e;
      e.pc   = a;
      e.inst = a ^ C_KEY;
      e.adel = 1'b0;
      req_q.push_back(a);
      dlv_q.push_back(e);
   endtask

   task automatic wait_empty(input int budget);
      int n = 0;
      while ((req_q.size() > 0 || dlv_q.size() > 0) && n < budget) begin
         @(negedge clk);
         #1;
         n++;
      end
      check("wait_empty_timeout", {31'd0, n >= budget}, 32'd0);
      repeat (2) @(negedge clk);
   endtask

   task automatic wait_valid(input int budget);
      int n = 0;
      while (!fs_valid && n < budget) begin
         @(negedge clk);
         n++;
      end
      check("wait_valid_timeout", {31'd0, n >= budget}, 32'd0);
   endtask

   task automatic redirect(input logic ws, input logic [31:0] ep, input logic br, input logic [31:0] bt);
      @(posedge clk);
      #2;
      ws_handle_ex = ws;
      ex_pc        = ep;
      br_taken     = br;
      br_target    = bt;
      @(posedge clk);
      #2;
      ws_handle_ex = 1'b0;
      br_taken     = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      dlv_t e;
      // Reset values
      repeat (3) @(negedge clk);
      check("rst_req", {31'd0, inst_req}, 32'd0);
      check("rst_valid", {31'd0, fs_valid}, 32'd0);
      check("rst_adel", {31'd0, fs_adel}, 32'd0);
      check("rst_inst", fs_inst, 32'd0);
      check("rst_pc", fs_pc, 32'hbfc00000);

      // Sequential fetch from reset vector
      for (int i = 0; i < 4; i++) push_fetch(32'hbfc00000 + 32'(4 * i));
      @(posedge clk);
      #2;
      reset = 1'b0;
      wait_empty(100);

      // Stall in HOLD for 5 cycles
      allow_en = 1'b0;
      push_fetch(32'hbfc00010);
      wait_valid(50);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("stall_pc", fs_pc, 32'hbfc00010);
         check("stall_inst", fs_inst, 32'hbfc00010 ^ C_KEY);
         check("stall_req", {31'd0, inst_req}, 32'd0);
      end
      allow_en = 1'b1;
      wait_empty(50);

      // Flush while waiting for data: response for the old PC is dropped
      lat = 3;
      req_q.push_back(32'hbfc00014);
      push_fetch(32'hbfc00380);
      wait (busy);
      redirect(1'b1, 32'hbfc00380, 1'b0, 32'd0);
      wait_empty(100);
      lat = 1;

      // Flush and branch together while request is unaccepted for 3 cycles
      aok_en = 1'b0;
      redirect(1'b1, 32'hbfc00500, 1'b1, 32'h80001000);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("req_hold_addr", inst_addr, 32'hbfc00384);
         check("req_hold_req", {31'd0, inst_req}, 32'd1);
      end
      req_q.push_back(32'hbfc00384);
      push_fetch(32'hbfc00500);
      aok_en = 1'b1;
      wait_empty(100);

      // Branch in HOLD with same-cycle allowin, to a misaligned target
      allow_en = 1'b0;
      req_q.push_back(32'hbfc00504);
      wait_valid(50);
      @(posedge clk);
      #2;
      br_taken    = 1'b1;
      br_target   = 32'h80000002;
      allow_en    = 1'b1;
      force_allow = 1'b1;
      @(posedge clk);
      #2;
      br_taken    = 1'b0;
      allow_en    = 1'b0;
      force_allow = 1'b0;
      wait_valid(50);
      check("adel_flag", {31'd0, fs_adel}, 32'd1);
      check("adel_inst", fs_inst, 32'd0);
      check("adel_pc", fs_pc, 32'h80000002);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("adel_noreq", {31'd0, inst_req}, 32'd0);
      end
      e.pc   = 32'h80000002;
      e.inst = 32'd0;
      e.adel = 1'b1;
      dlv_q.push_back(e);
      allow_en = 1'b1;
      wait_empty(50);
      check("req_q_drained", req_q.size(), 32'd0);

      // Reset mid-operation
      @(posedge clk);
      #2;
      reset = 1'b1;
      repeat (2) @(negedge clk);
      check("rst2_valid", {31'd0, fs_valid}, 32'd0);
      check("rst2_adel", {31'd0, fs_adel}, 32'd0);
      check("rst2_pc", fs_pc, 32'hbfc00000);
      push_fetch(32'hbfc00000);
      @(posedge clk);
      #2;
      reset = 1'b0;
      wait_empty(50);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule

`default_nettype wire
